bin_to_bcd_converter: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). One conversion per request.
- Sits directly upstream of the 4-digit display multiplexer. It converts the servo position/angle value into four BCD digits, which feed the multiplexer's data_digit1..data_digit4 inputs.
- Digit outputs are registered and hold their value between conversions, so the display never shows partial results.

---
 rtl/bin_to_bcd_converter.sv | 144 ++++++++++++++
 tb/tb_bin_to_bcd_converter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding a 4-digit display.
// Digits are registered and only change on a completed conversion or on reset.
module bin_to_bcd_converter #(
    parameter int WIDTH     = 14,
    parameter int MAX_VALUE = 9999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       data_digit1,
    output logic [3:0]       data_digit2,
    output logic [3:0]       data_digit3,
    output logic [3:0]       data_digit4
);

    localparam int          CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [15:0] MAX_V  = 16'(MAX_VALUE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] bin_q,      bin_d;
    logic [WIDTH-1:0] cap_q,      cap_d;
    logic [15:0]      scratch_q,  scratch_d;
    logic [CW-1:0]    count_q,    count_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      digits_q,   digits_d;
    logic [15:0]      scratch_adj_s;
    logic [15:0]      cap_ext_s;

    function automatic logic [3:0] add3(input logic [3:0] n);
        if (n >= 4'd5) begin
            return n + 4'd3;
        end else begin
            return n;
        end
    endfunction

    // Nibble pre-adjust ahead of the shift; the saturation check uses the captured input.
    always_comb begin
        scratch_adj_s = {add3(scratch_q[15:12]), add3(scratch_q[11:8]),
                         add3(scratch_q[7:4]),   add3(scratch_q[3:0])};
        cap_ext_s     = 16'(cap_q);
    end

    // Next-state and datapath for the IDLE/SHIFT/UPDATE sequence.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        cap_d      = cap_q;
        scratch_d  = scratch_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        digits_d   = digits_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d     = bin_in;
                    cap_d     = bin_in;
                    scratch_d = 16'd0;
                    count_d   = {CW{1'b0}};
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                scratch_d = {scratch_adj_s[14:0], bin_q[WIDTH-1]};
                bin_d     = {bin_q[WIDTH-2:0], 1'b0};
                count_d   = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d = UPDATE;
                end else begin
                    state_d = SHIFT;
                end
            end
            UPDATE: begin
                // The scratch wraps above 9999, so saturation must not look at it.
                if (cap_ext_s > MAX_V) begin
                    digits_d   = 16'h9999;
                    overflow_d = 1'b1;
                end else begin
                    digits_d   = scratch_q;
                    overflow_d = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bin_q      <= {WIDTH{1'b0}};
            cap_q      <= {WIDTH{1'b0}};
            scratch_q  <= 16'd0;
            count_q    <= {CW{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            digits_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            cap_q      <= cap_d;
            scratch_q  <= scratch_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            digits_q   <= digits_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign overflow    = overflow_q;
    assign data_digit1 = digits_q[3:0];
    assign data_digit2 = digits_q[7:4];
    assign data_digit3 = digits_q[11:8];
    assign data_digit4 = digits_q[15:12];

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed self-checking bench for bin_to_bcd_converter (default WIDTH=14).
module tb_bin_to_bcd_converter;

    localparam int WIDTH = 14;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] bin_in;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [3:0]       data_digit1;
    logic [3:0]       data_digit2;
    logic [3:0]       data_digit3;
    logic [3:0]       data_digit4;

    int checks_r   = 0;
    int failures_r = 0;

    bin_to_bcd_converter #(.WIDTH(WIDTH), .MAX_VALUE(9999)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bin_in      (bin_in),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .data_digit1 (data_digit1),
        .data_digit2 (data_digit2),
        .data_digit3 (data_digit3),
        .data_digit4 (data_digit4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] digits_s();
        return {data_digit4, data_digit3, data_digit2, data_digit1};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            failures_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a conversion; returns just after the accepting edge.
    task automatic start_conv(input logic [WIDTH-1:0] value);
        start  = 1'b1;
        bin_in = value;
        tick();
        start  = 1'b0;
        bin_in = WIDTH'($urandom);
        check_eq("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Waits for done (bounded); checks digits hold the old value until then.
    task automatic run_until_done(input logic [15:0] hold, output int lat, output int busy_cnt);
        logic held;
        logic seen;
        held     = 1'b1;
        seen     = 1'b0;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (digits_s() != hold) held = 1'b0;
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("digits_held", 32'(held), 32'd1);
        check_eq("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic convert(input logic [WIDTH-1:0] value, input logic [15:0] exp_digits,
                           input logic exp_ovf);
        int lat;
        int bc;
        logic [15:0] prev;
        prev = digits_s();
        start_conv(value);
        run_until_done(prev, lat, bc);
        check_eq("latency", 32'(lat), 32'(WIDTH + 1));
        check_eq("digits", 32'(digits_s()), 32'(exp_digits));
        check_eq("overflow", 32'(overflow), 32'(exp_ovf));
        tick();
        check_eq("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int bc;
        int extra_done;
        logic held;

        rst_n  = 1'b0;
        start  = 1'b1;
        bin_in = 14'd1234;
        // Reset held with start asserted
        repeat (3) tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_digits", 32'(digits_s()), 32'h0000);

        // First edge with rst_n=1 accepts the still-asserted start
        rst_n = 1'b1;
        tick();
        start = 1'b0;
        check_eq("rel_busy", 32'(busy), 32'd1);
        run_until_done(16'h0000, lat, bc);
        check_eq("rel_latency", 32'(lat), 32'd15);
        check_eq("rel_digits", 32'(digits_s()), 32'h1234);
        repeat (3) tick();

        // Nominal with busy width and 50-cycle stability
        start_conv(14'd1234);
        run_until_done(16'h1234, lat, bc);
        check_eq("nom_latency", 32'(lat), 32'd15);
        check_eq("nom_busy_cycles", 32'(bc), 32'd15);
        check_eq("nom_digits", 32'(digits_s()), 32'h1234);
        check_eq("nom_ovf", 32'(overflow), 32'd0);
        held = 1'b1;
        extra_done = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (digits_s() != 16'h1234) held = 1'b0;
            if (done) extra_done++;
        end
        check_eq("nom_stable", 32'(held), 32'd1);
        check_eq("nom_no_extra_done", 32'(extra_done), 32'd0);

        // Boundary values and saturation
        convert(14'd0,     16'h0000, 1'b0);
        convert(14'd9999,  16'h9999, 1'b0);
        convert(14'd16383, 16'h9999, 1'b1);
        convert(14'd10,    16'h0010, 1'b0);
        convert(14'd10000, 16'h9999, 1'b1);
        convert(14'd5309,  16'h5309, 1'b0);

        // Start while busy is ignored
        start_conv(14'd42);
        for (int i = 0; i < 3; i++) tick();
        start  = 1'b1;
        bin_in = 14'd777;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            tick();
        end
        check_eq("rej_done", 32'(done), 32'd1);
        check_eq("rej_digits", 32'(digits_s()), 32'h0042);
        extra_done = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done) extra_done++;
        end
        check_eq("rej_no_second", 32'(extra_done), 32'd0);
        check_eq("rej_digits_after", 32'(digits_s()), 32'h0042);

        // Back-to-back: start during the done cycle
        start_conv(14'd5678);
        run_until_done(16'h0042, lat, bc);
        check_eq("b2b_first", 32'(digits_s()), 32'h5678);
        start  = 1'b1;
        bin_in = 14'd9;
        tick();
        start  = 1'b0;
        run_until_done(16'h5678, lat, bc);
        check_eq("b2b_gap", 32'(lat + 1), 32'd16);
        check_eq("b2b_second", 32'(digits_s()), 32'h0009);

        // Reset in the middle of a conversion
        repeat (2) tick();
        start_conv(14'd4321);
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("mid_busy", 32'(busy), 32'd0);
        check_eq("mid_digits", 32'(digits_s()), 32'h0000);
        extra_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) extra_done++;
        end
        check_eq("mid_no_done", 32'(extra_done), 32'd0);
        check_eq("mid_digits_after", 32'(digits_s()), 32'h0000);
        convert(14'd4321, 16'h4321, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
